// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered priority encoder with a valid/ready input side and
// a valid/ready output side. Grant is either fixed (highest index wins) or
// round-robin (search downward from a pointer, granted index becomes lowest next).
//
// Handshake: an input vector is accepted on a cycle where req_valid_i and
// req_ready_o are both 1; an output is consumed on a cycle where out_valid_o and
// out_ready_i are both 1. req_ready_o = !out_valid_o || out_ready_i, so a new
// vector can replace a consumed output in the same cycle with no bubble.
module prio_encoder_rr #(
    parameter int N      = 4,
    parameter int ROTATE = 0,
    localparam int W     = (N > 2) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] onehot_o,
    output logic         multi_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         drop_o
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic         multi_q, multi_d;
    logic         drop_q, drop_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         accept;
    logic         consume;
    logic [W-1:0] start;
    logic [W-1:0] grant;
    logic         found;

    assign req_ready_o = !out_valid_q || out_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign consume     = out_valid_q && out_ready_i;

    assign idx_o       = idx_q;
    assign onehot_o    = onehot_q;
    assign multi_o     = multi_q;
    assign out_valid_o = out_valid_q;
    assign drop_o      = drop_q;

    // Grant search: walk start, start-1, ... wrapping below 0 to N-1; fixed
    // priority is simply the same walk always starting from N-1.
    always_comb begin
        start = (ROTATE != 0) ? ptr_q : LAST_IDX;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = int'(start) - k;
            if (c < 0) c = c + N;
            if (!found && req_i[W'(c)]) begin
                found = 1'b1;
                grant = W'(c);
            end
        end
    end

    // Next-state: accept loads or drops, a bare consume clears valid, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        onehot_d    = onehot_q;
        multi_d     = multi_q;
        drop_d      = 1'b0;
        ptr_d       = ptr_q;
        if (accept) begin
            if (found) begin
                out_valid_d = 1'b1;
                idx_d       = grant;
                onehot_d    = {{(N-1){1'b0}}, 1'b1} << grant;
                multi_d     = ($countones(req_i) >= 2);
                if (ROTATE != 0) begin
                    // Granted index becomes the lowest priority next time.
                    ptr_d = (grant == '0) ? LAST_IDX : grant - 1'b1;
                end
            end else begin
                // All-zero vector: discard it. Being accepted implies any old
                // output was consumed, so valid drops.
                drop_d      = 1'b1;
                out_valid_d = 1'b0;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            onehot_q    <= '0;
            multi_q     <= 1'b0;
            drop_q      <= 1'b0;
            ptr_q       <= LAST_IDX;
        end else begin
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            onehot_q    <= onehot_d;
            multi_q     <= multi_d;
            drop_q      <= drop_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: three instances (N=4 fixed, N=4 round-robin,
// N=3 round-robin) share one stimulus stream and are each compared with a
// behavioural model every cycle, plus directed constant checks.
module tb_prio_encoder_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       req_valid;
  logic       out_ready;

  logic       d0_rdy, d0_vld, d0_mul, d0_drp;
  logic [1:0] d0_idx;
  logic [3:0] d0_oh;
  logic       d1_rdy, d1_vld, d1_mul, d1_drp;
  logic [1:0] d1_idx;
  logic [3:0] d1_oh;
  logic       d2_rdy, d2_vld, d2_mul, d2_drp;
  logic [1:0] d2_idx;
  logic [2:0] d2_oh;

  int checks = 0;
  int errors = 0;

  // model state per instance
  int n_of   [3] = '{4, 4, 3};
  int rot_of [3] = '{0, 1, 1};
  int m_valid[3];
  int m_idx  [3];
  int m_oh   [3];
  int m_multi[3];
  int m_drop [3];
  int m_ptr  [3];

  // clock/reset block
  always #5 clk = ~clk;

  prio_encoder_rr #(.N(4), .ROTATE(0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req), .req_valid_i(req_valid), .req_ready_o(d0_rdy),
    .idx_o(d0_idx), .onehot_o(d0_oh), .multi_o(d0_mul), .out_valid_o(d0_vld),
    .out_ready_i(out_ready), .drop_o(d0_drp));

  prio_encoder_rr #(.N(4), .ROTATE(1)) dut1 (
    .clk(clk), .rst(rst), .req_i(req), .req_valid_i(req_valid), .req_ready_o(d1_rdy),
    .idx_o(d1_idx), .onehot_o(d1_oh), .multi_o(d1_mul), .out_valid_o(d1_vld),
    .out_ready_i(out_ready), .drop_o(d1_drp));

  prio_encoder_rr #(.N(3), .ROTATE(1)) dut2 (
    .clk(clk), .rst(rst), .req_i(req[2:0]), .req_valid_i(req_valid), .req_ready_o(d2_rdy),
    .idx_o(d2_idx), .onehot_o(d2_oh), .multi_o(d2_mul), .out_valid_o(d2_vld),
    .out_ready_i(out_ready), .drop_o(d2_drp));

  // scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant from the rules: among set bits pick the one closest below the pointer
  // (cyclic distance); fixed priority is distance from the top index.
  function automatic int model_grant(int r, int n, int rot, int p);
    int best = -1;
    int bestd = n;
    for (int g = 0; g < n; g++) begin
      if (((r >> g) & 1) != 0) begin
        int d;
        d = (rot != 0) ? ((p - g + n) % n) : (n - 1 - g);
        if (d < bestd) begin
          bestd = d;
          best = g;
        end
      end
    end
    return best;
  endfunction

  function automatic int model_ready(int i);
    return ((m_valid[i] == 0) || (out_ready == 1'b1)) ? 1 : 0;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int n, r, rdy, g;
      n = n_of[i];
      r = int'(req) & ((1 << n) - 1);
      rdy = model_ready(i);
      if (rst) begin
        m_valid[i] = 0; m_idx[i] = 0; m_oh[i] = 0; m_multi[i] = 0; m_drop[i] = 0;
        m_ptr[i] = n - 1;
      end else begin
        m_drop[i] = 0;
        if (req_valid && rdy != 0) begin
          if (r == 0) begin
            m_drop[i] = 1;
            m_valid[i] = 0;
          end else begin
            g = model_grant(r, n, rot_of[i], m_ptr[i]);
            m_valid[i] = 1;
            m_idx[i] = g;
            m_oh[i] = 1 << g;
            m_multi[i] = ($countones(r) >= 2) ? 1 : 0;
            if (rot_of[i] != 0) m_ptr[i] = (g - 1 + n) % n;
          end
        end else if (m_valid[i] != 0 && out_ready) begin
          m_valid[i] = 0;
        end
      end
    end
  endtask

  task automatic chk_inst(input int i, input logic vld, input logic [1:0] idx,
                          input logic [3:0] oh, input logic mul, input logic drp,
                          input logic [1:0] ptr);
    chk($sformatf("valid[%0d]", i), 32'(vld), 32'(m_valid[i]));
    chk($sformatf("idx[%0d]", i), 32'(idx), 32'(m_idx[i]));
    chk($sformatf("onehot[%0d]", i), 32'(oh), 32'(m_oh[i]));
    chk($sformatf("multi[%0d]", i), 32'(mul), 32'(m_multi[i]));
    chk($sformatf("drop[%0d]", i), 32'(drp), 32'(m_drop[i]));
    chk($sformatf("ptr[%0d]", i), 32'(ptr), 32'(m_ptr[i]));
  endtask

  // driver: one clock cycle of stimulus with checks before and after the edge
  task automatic cyc(input logic r, input logic v, input logic [3:0] q, input logic o);
    rst = r; req_valid = v; req = q; out_ready = o;
    #1;
    chk("ready[0]", 32'(d0_rdy), 32'(model_ready(0)));
    chk("ready[1]", 32'(d1_rdy), 32'(model_ready(1)));
    chk("ready[2]", 32'(d2_rdy), 32'(model_ready(2)));
    model_step();
    @(posedge clk);
    #1;
    chk_inst(0, d0_vld, d0_idx, d0_oh, d0_mul, d0_drp, dut0.ptr_q);
    chk_inst(1, d1_vld, d1_idx, d1_oh, d1_mul, d1_drp, dut1.ptr_q);
    chk_inst(2, d2_vld, d2_idx, {1'b0, d2_oh}, d2_mul, d2_drp, dut2.ptr_q);
    chk("ptr_lt_n[2]", 32'(dut2.ptr_q < 2'd3), 32'd1);
  endtask

  initial begin
    int exp36[5];
    int exp40[5];
    exp36 = '{3, 2, 1, 0, 3};
    exp40 = '{2, 1, 0, 2, 1};
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 0; m_idx[i] = 0; m_oh[i] = 0; m_multi[i] = 0; m_drop[i] = 0;
      m_ptr[i] = n_of[i] - 1;
    end

    // reset
    cyc(1'b1, 1'b1, 4'hF, 1'b1);
    cyc(1'b1, 1'b0, 4'h0, 1'b1);
    chk("rst_valid", 32'(d0_vld), 32'd0);
    chk("rst_ptr1", 32'(dut1.ptr_q), 32'd3);
    chk("rst_ready1", 32'(d1_rdy), 32'd1);

    // fixed priority directed vectors
    cyc(1'b0, 1'b1, 4'b0001, 1'b1);
    chk("fix_idx_a", 32'(d0_idx), 32'd0); chk("fix_oh_a", 32'(d0_oh), 32'b0001);
    chk("fix_mul_a", 32'(d0_mul), 32'd0);
    cyc(1'b0, 1'b1, 4'b0100, 1'b1);
    chk("fix_idx_b", 32'(d0_idx), 32'd2); chk("fix_oh_b", 32'(d0_oh), 32'b0100);
    chk("fix_mul_b", 32'(d0_mul), 32'd0);
    cyc(1'b0, 1'b1, 4'b1111, 1'b1);
    chk("fix_idx_c", 32'(d0_idx), 32'd3); chk("fix_oh_c", 32'(d0_oh), 32'b1000);
    chk("fix_mul_c", 32'(d0_mul), 32'd1);

    // round-robin from reset, N=4 and N=3
    cyc(1'b1, 1'b0, 4'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b1, 4'hF, 1'b1);
      chk($sformatf("rr4_idx%0d", k), 32'(d1_idx), 32'(exp36[k]));
      chk($sformatf("rr4_mul%0d", k), 32'(d1_mul), 32'd1);
      chk($sformatf("rr3_idx%0d", k), 32'(d2_idx), 32'(exp40[k]));
    end

    // backpressure
    cyc(1'b0, 1'b1, 4'b0010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 4'hF, 1'b0);
      chk($sformatf("bp_idx%0d", k), 32'(d0_idx), 32'd1);
      chk($sformatf("bp_ready%0d", k), 32'(d0_rdy), 32'd0);
    end
    cyc(1'b0, 1'b1, 4'hF, 1'b1);
    chk("bp_taken", 32'(d0_idx), 32'd3);

    // zero vector
    cyc(1'b1, 1'b0, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'h0, 1'b1);
    chk("zero_drop", 32'(d1_drp), 32'd1);
    chk("zero_valid", 32'(d1_vld), 32'd0);
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    chk("zero_drop_end", 32'(d1_drp), 32'd0);
    cyc(1'b0, 1'b1, 4'hF, 1'b1);
    chk("zero_next_idx", 32'(d1_idx), 32'd3);

    // reset mid-operation
    cyc(1'b0, 1'b0, 4'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'b0100, 1'b0);
    chk("mid_idx", 32'(d0_idx), 32'd2);
    cyc(1'b1, 1'b1, 4'hF, 1'b1);
    chk("mid_valid", 32'(d1_vld), 32'd0);
    chk("mid_idx0", 32'(d1_idx), 32'd0);
    chk("mid_ptr", 32'(dut1.ptr_q), 32'd3);
    chk("mid_ptr3", 32'(dut2.ptr_q), 32'd2);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
          4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of request inputs (legal range 2..32).
REQ-002 The block SHALL have parameter ROTATE, default 0, meaning 0 = fixed priority (highest index wins) and 1 = round-robin priority.
REQ-003 The block SHALL define localparam W = max(1, ceil(log2(N))), the index width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk  input  1  clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  synchronous active-high reset.
REQ-007 Port req_i  input  N  request vector; bit k is request k.
REQ-008 Port req_valid_i  input  1  req_i is presented for acceptance.
REQ-009 Port req_ready_o  output  1  block can accept req_i this cycle.
REQ-010 Port idx_o  output  W  encoded index of the granted request.
REQ-011 Port onehot_o  output  N  one-hot form of idx_o.
REQ-012 Port multi_o  output  1  more than one req_i bit was set in the accepted vector.
REQ-013 Port out_valid_o  output  1  idx_o/onehot_o/multi_o are valid.
REQ-014 Port out_ready_i  input  1  consumer takes the output this cycle.
REQ-015 Port drop_o  output  1  one-cycle pulse: an all-zero vector was accepted and discarded.

Function
REQ-016 Combinational ready SHALL be: req_ready_o = !out_valid_o || out_ready_i.
REQ-017 Accept SHALL occur when req_valid_i && req_ready_o; no state SHALL change on a non-accept cycle, except out_valid_o clearing on a consumed output and drop_o returning to 0.
REQ-018 An accept with req_i != 0 SHALL load idx_o, onehot_o and multi_o and set out_valid_o on the next edge, giving a latency of 1 cycle.
REQ-019 An accept with req_i == 0 SHALL set drop_o for exactly 1 cycle, SHALL leave the pointer unchanged, and SHALL clear out_valid_o if the previous output was consumed.
REQ-020 A consume (out_valid_o && out_ready_i) without a non-zero accept SHALL clear out_valid_o on the next edge.
REQ-021 A consume and a non-zero accept in the same cycle SHALL replace the output with no bubble, leaving out_valid_o at 1.
REQ-022 While out_valid_o && !out_ready_i, the outputs SHALL hold stable, req_ready_o SHALL be 0, and the pointer SHALL hold.
REQ-023 With ROTATE=0, the grant SHALL be the highest set index of req_i.
REQ-024 With ROTATE=1, the block SHALL hold a W-bit pointer ptr, and the search order SHALL be ptr, ptr-1, ..., 0, N-1, ..., ptr+1 (mod N).
REQ-025 With ROTATE=1, after a non-zero accept granting g, ptr SHALL become (g-1) mod N, making g the lowest priority next time.
REQ-026 onehot_o SHALL equal 1 << idx_o whenever out_valid_o = 1.
REQ-027 multi_o SHALL be 1 exactly when popcount(accepted req_i) >= 2.
REQ-028 For N that is not a power of two, ptr wrap SHALL go 0 -> N-1, and ptr SHALL never hold a value >= N.
REQ-029 With ROTATE=0, the pointer logic SHALL be absent or constant and SHALL have no effect on the grant.

Reset
REQ-030 While rst = 1 at a clock edge: out_valid_o = 0, idx_o = 0, onehot_o = 0, multi_o = 0, drop_o = 0, and ptr = N-1.
REQ-031 Reset SHALL take priority over any simultaneous accept or consume.
REQ-032 A pending unconsumed output SHALL be discarded by reset.
REQ-033 req_ready_o SHALL be 1 during the first cycle after reset.
REQ-034 There SHALL be no asynchronous reset path.

Verification
REQ-035 ROTATE=0, N=4, out_ready_i=1: accept 0001, 0100, 1111 -> idx_o 0, 2, 3 one cycle after each; multi_o 0, 0, 1; onehot_o 0001, 0100, 1000.
REQ-036 ROTATE=1, N=4, after reset, five back-to-back accepts of 1111 -> idx_o 3, 2, 1, 0, 3; multi_o = 1 on each.
REQ-037 Backpressure: accept 0010 with out_ready_i=0 held 3 cycles -> idx_o = 1 stable and req_ready_o = 0 throughout; the next accept is taken only in the cycle out_ready_i = 1.
REQ-038 Zero vector: ROTATE=1, accept 0000 -> drop_o = 1 for 1 cycle and out_valid_o = 0; a following 1111 -> idx_o 3 (ptr unchanged).
REQ-039 Reset mid-operation: out_valid_o = 1 with idx_o = 2, assert rst 1 cycle with req_valid_i = 1 -> all outputs 0 next cycle, the request is not taken, and ptr = N-1.
REQ-040 ROTATE=1, N=3: repeated accepts of 111 -> idx_o 2, 1, 0, 2; ptr never equals 3.
